// File: rtl/uart_rs232_rx.sv
// rtl/uart_rs232_rx.sv - RS-232 UART receiver, 16x oversampled, 5..8 data bits, one stop bit
//
// Purpose: synchronizes the asynchronous Rx line, detects a start edge, samples
// the data bits LSB-first and the stop bit, and reports the received word with
// a one-Clk RxDone strobe.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   - every start/data/stop decision is a 2-of-3 vote over three
//               consecutive ticks around the bit centre (rejects 1-tick glitches)
//   undefined - single sample at the mid-bit tick
//
// Ports:
//   Clk      in   system clock, rising edge
//   Rst      in   synchronous active-high reset
//   RxEn     in   receiver enable; low aborts any frame and holds IDLE
//   Tick     in   one-Clk enable at 16x the baud rate
//   NBits    in   data bits per frame (5..8, anything else means 8)
//   Rx       in   asynchronous serial line, idles high
//   RxData   out  last received word, right-justified, upper bits zero
//   RxDone   out  one-Clk pulse at frame completion
//   FrameErr out  stop bit sampled low; valid with RxDone, held until the next one
//   Busy     out  receiver is not in IDLE

module uart_rs232_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEn,
  input  logic       Tick,
  input  logic [3:0] NBits,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Decision points within a bit window. With voting, the start decision is
  // one tick later and the data/stop windows vote over counters 13..15, which
  // lands on bit-centre -1/0/+1 because of that one-tick shift.
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] START_V0  = 4'd6;
  localparam logic [3:0] START_V1  = 4'd7;
  localparam logic [3:0] START_DEC = 4'd8;
  localparam logic [3:0] BIT_V0    = 4'd13;
  localparam logic [3:0] BIT_V1    = 4'd14;
`else
  localparam logic [3:0] START_DEC = 4'd7;
`endif
  localparam logic [3:0] BIT_DEC   = 4'd15;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d;
  logic                   start_edge;
  logic [3:0]             cnt;
  logic [2:0]             bit_idx;
  logic [2:0]             n_m1;
  logic [2:0]             n_m1_in;
  logic [3:0]             nbits_m1;
  logic [7:0]             shreg;
  logic                   samp;

  // Input synchronizer; reset to the idle-high line level so that reset
  // release never looks like a start edge.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= '1;
      rx_s_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
      rx_s_d <= rx_s;
    end
  end

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_s_d & ~rx_s;

  // Last bit index for this frame: NBits-1 for 5..8, else 7.
  assign nbits_m1 = NBits - 4'd1;
  always_comb begin
    n_m1_in = 3'd7;
    if (NBits >= 4'd5 && NBits <= 4'd8)
      n_m1_in = nbits_m1[2:0];
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] vote;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      vote <= 2'b11;
    end else if (Tick) begin
      if ((state == START && cnt == START_V0) || (state != START && cnt == BIT_V0))
        vote[0] <= rx_s;
      if ((state == START && cnt == START_V1) || (state != START && cnt == BIT_V1))
        vote[1] <= rx_s;
    end
  end

  assign samp = (vote[0] & vote[1]) | (vote[0] & rx_s) | (vote[1] & rx_s);
`else
  assign samp = rx_s;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      bit_idx  <= 3'd0;
      n_m1     <= 3'd7;
      shreg    <= 8'h00;
      RxData   <= 8'h00;
      RxDone   <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      RxDone <= 1'b0;
      if (!RxEn) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // A tick coinciding with the edge is deliberately not counted.
            if (start_edge) begin
              state   <= START;
              cnt     <= 4'd0;
              bit_idx <= 3'd0;
              shreg   <= 8'h00;
              n_m1    <= n_m1_in;
            end
          end
          START: begin
            if (Tick) begin
              if (cnt == START_DEC) begin
                if (samp) begin
                  state <= IDLE;
                end else begin
                  state   <= DATA;
                  cnt     <= 4'd0;
                  bit_idx <= 3'd0;
                end
              end else begin
                cnt <= cnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (Tick) begin
              cnt <= cnt + 4'd1;
              if (cnt == BIT_DEC) begin
                shreg[bit_idx] <= samp;
                bit_idx        <= bit_idx + 3'd1;
                if (bit_idx == n_m1)
                  state <= STOP;
              end
            end
          end
          STOP: begin
            if (Tick) begin
              cnt <= cnt + 4'd1;
              if (cnt == BIT_DEC) begin
                RxDone   <= 1'b1;
                FrameErr <= ~samp;
                RxData   <= shreg;
                state    <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rs232_rx.sv
// tb/tb_uart_rs232_rx.sv - directed self-checking bench for uart_rs232_rx
module tb_uart_rs232_rx;

  logic       Clk   = 1'b0;
  logic       Rst   = 1'b1;
  logic       RxEn  = 1'b1;
  logic       Tick  = 1'b0;
  logic [3:0] NBits = 4'd8;
  logic       Rx    = 1'b1;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       Busy;

  int total = 0;
  int bad   = 0;

  int         tick_div  = 0;
  int         tick_cnt  = 0;
  int         done_cnt  = 0;
  bit         busy_seen = 1'b0;
  int         done_tick[$];
  logic [7:0] done_data[$];

  int d0;
  int gb;

  uart_rs232_rx #(.SYNC_STAGES(2)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .RxEn     (RxEn),
    .Tick     (Tick),
    .NBits    (NBits),
    .Rx       (Rx),
    .RxData   (RxData),
    .RxDone   (RxDone),
    .FrameErr (FrameErr),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  // Tick: one Clk in every four, changed 1 ns after the rising edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      tick_div = (tick_div + 1) % 4;
      Tick     = (tick_div == 0);
    end
  end

  always @(negedge Clk) begin
    if (Tick) tick_cnt++;
    if (Busy) busy_seen = 1'b1;
    if (RxDone) begin
      done_cnt++;
      done_tick.push_back(tick_cnt);
      done_data.push_back(RxData);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Returns 2 ns after the rising edge on which the n-th further Tick was sampled.
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge Clk);
      while (!Tick) @(posedge Clk);
    end
    #2;
  endtask

  // Start bit, nb data bits LSB-first, one stop bit of value stop_v (left on the line).
  // glitch_bit >= 0 inverts that data bit for the single tick at its centre.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic stop_v, input int glitch_bit);
    Rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < nb; i++) begin
      Rx = d[i];
      if (i == glitch_bit) begin
        wait_ticks(7);
        Rx = ~d[i];
        wait_ticks(1);
        Rx = d[i];
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    Rx = stop_v;
    wait_ticks(16);
  endtask

  initial begin
    // reset state
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("rst_data", RxData, 8'h00);
    chk("rst_done", RxDone, 1'b0);
    chk("rst_ferr", FrameErr, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    Rst = 1'b0;
    wait_ticks(4);

    // 8N1 0x5A
    d0 = done_cnt;
    send_frame(8'h5A, 8, 1'b1, -1);
    wait_ticks(4);
    chk("8n1_ndone", done_cnt, d0 + 1);
    chk("8n1_data", RxData, 8'h5A);
    chk("8n1_ferr", FrameErr, 1'b0);
    chk("8n1_busy", Busy, 1'b0);

    // 5-bit frame 5'b10110
    NBits = 4'd5;
    d0 = done_cnt;
    send_frame(8'h16, 5, 1'b1, -1);
    wait_ticks(4);
    chk("5b_ndone", done_cnt, d0 + 1);
    chk("5b_data", RxData, 8'h16);

    // NBits=12 behaves as 8
    NBits = 4'd12;
    send_frame(8'hC3, 8, 1'b1, -1);
    wait_ticks(4);
    chk("12b_data", RxData, 8'hC3);
    NBits = 4'd8;

    // false start: 4-tick low pulse
    d0 = done_cnt;
    Rx = 1'b0;
    wait_ticks(4);
    Rx = 1'b1;
    wait_ticks(2);
    chk("fs_busy_hi", Busy, 1'b1);
    wait_ticks(4);
    chk("fs_busy_lo", Busy, 1'b0);
    chk("fs_ndone", done_cnt, d0);
    chk("fs_data", RxData, 8'hC3);

    // abort with RxEn during data bit 3 of 0x0F
    d0 = done_cnt;
    Rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      Rx = 1'b1;
      wait_ticks(16);
    end
    Rx = 1'b1;
    wait_ticks(8);
    chk("ab_busy_pre", Busy, 1'b1);
    RxEn = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("ab_idle", Busy, 1'b0);
    Rx = 1'b0;
    wait_ticks(40);
    Rx = 1'b1;
    wait_ticks(40);
    RxEn = 1'b1;
    wait_ticks(4);
    chk("ab_ndone", done_cnt, d0);
    chk("ab_data", RxData, 8'hC3);

    // framing error: 0xFF, stop low, line held low 40 ticks
    d0 = done_cnt;
    send_frame(8'hFF, 8, 1'b0, -1);
    chk("fe_ndone", done_cnt, d0 + 1);
    chk("fe_ferr", FrameErr, 1'b1);
    chk("fe_data", RxData, 8'hFF);
    busy_seen = 1'b0;
    wait_ticks(40);
    chk("fe_no_restart", busy_seen, 1'b0);
    chk("fe_ndone2", done_cnt, d0 + 1);
    Rx = 1'b1;
    wait_ticks(4);

    // reset mid-frame
    Rx = 1'b0;
    wait_ticks(16);
    Rx = 1'b1;
    wait_ticks(16);
    Rx = 1'b0;
    wait_ticks(8);
    chk("rm_busy_pre", Busy, 1'b1);
    Rst = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("rm_data", RxData, 8'h00);
    chk("rm_ferr", FrameErr, 1'b0);
    chk("rm_busy", Busy, 1'b0);
    chk("rm_done", RxDone, 1'b0);
    Rst = 1'b0;
    Rx  = 1'b1;
    wait_ticks(20);

    // back-to-back 0x01 then 0x80
    gb = -1;
`ifdef UART_RX_MAJORITY_EN
    gb = 2;
`endif
    d0 = done_cnt;
    send_frame(8'h01, 8, 1'b1, gb);
    send_frame(8'h80, 8, 1'b1, -1);
    wait_ticks(4);
    chk("b2b_ndone", done_cnt, d0 + 2);
    if (done_cnt == d0 + 2) begin
      chk("b2b_data0", done_data[d0], 8'h01);
      chk("b2b_data1", done_data[d0 + 1], 8'h80);
      chk("b2b_gap", done_tick[d0 + 1] - done_tick[d0], 160);
    end
    chk("b2b_ferr", FrameErr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rs232_rx.md
# uart_rs232_rx

RS-232 UART receiver paired with the `UART_rs232_tx` transmitter on the same 16x oversampling `Tick` enable. It synchronizes the asynchronous `Rx` line and detects a start bit. It then samples 5–8 data bits LSB-first plus one stop bit and presents the received word with a one-cycle `RxDone` strobe. It sits between the board UART pin and the user logic that consumes received bytes.

## Interface
- `SYNC_STAGES`, default 2: number of flip-flops in the `Rx` input synchronizer (legal 2..3).
- `Clk` input 1: system clock; all logic is on the rising edge.
- `Rst` input 1: reset, synchronous and active-high.
- `RxEn` input 1: receiver enable. Low forces IDLE and aborts any frame in progress.
- `Tick` input 1: one-`Clk`-wide enable pulse at 16x the baud rate, synchronous to `Clk`.
- `NBits` input 4: data bits per frame. Legal values are 5..8; any other value is treated as 8.
- `Rx` input 1: serial line, asynchronous, idles high.
- `RxData` output 8: last received word, right-justified; bits at and above `NBits` are 0.
- `RxDone` output 1: one-`Clk` pulse when a frame completes.
- `FrameErr` output 1: valid with `RxDone`; 1 means the stop bit was sampled low.
- `Busy` output 1: high in any state other than IDLE.

## Operation
- `Rx` passes through `SYNC_STAGES` flip-flops, giving `rx_s`. A start edge is `rx_s` going 1→0 between consecutive `Clk` cycles.
- States: IDLE, START, DATA, STOP.
  - **IDLE:** on a start edge with `RxEn`=1, go to START and clear the tick counter to 0.
  - **START:** count `Tick` pulses. At the 8th tick (counter 7), sample `rx_s`.
    - If `rx_s`=1 (false start), go to IDLE with no `RxDone`.
    - If `rx_s`=0, go to DATA with counter=0 and bit index=0.
  - **DATA:** on each 16th tick (counter 15), sample `rx_s` into `RxData` position `bit index`, then increment the index. After the sample at index N−1, go to STOP. The counter wraps 15→0 naturally; no explicit reload is needed.
  - **STOP:** at the 16th tick, sample `rx_s`.
    - Drive `RxDone`=1 for one `Clk` and `FrameErr`=~`rx_s`.
    - Update `RxData` with the assembled word. Bits ≥N are zero, and the shift register is cleared at START.
    - Go to IDLE.
- Counter width is 4 bits; bit index is 3 bits. N = `NBits` when 5 ≤ `NBits` ≤ 8, otherwise 8. N is latched at entry to START; mid-frame changes to `NBits` are ignored.
- `RxData` and `FrameErr` hold their values until the next `RxDone`. Frames aborted by a false start or by `RxEn` do not change them.
- After a framing error with the line still low, no new frame starts until `rx_s` returns high and a fresh 1→0 edge occurs.
- `RxEn` deasserted in any state returns to IDLE on the next `Clk`, with no `RxDone`.
- `Rst` returns to IDLE. It has priority over all other inputs.

## Timing
- Reset values: `RxData`=8'h00, `RxDone`=0, `FrameErr`=0, `Busy`=0. Counter, bit index and shift register are all 0.
- Start-edge latency: `SYNC_STAGES`+1 `Clk` cycles from the `Rx` falling edge to `Busy`=1.
- `RxDone` asserts in the `Clk` cycle after the `Tick` that samples the mid-stop bit. That is (16·(N+1)+8) ticks after the start edge is detected.
- `RxData` and `FrameErr` are valid in the same cycle as `RxDone`.
- If a `Tick` arrives in the same `Clk` cycle as the start edge, that tick is not counted.
- The next start edge may be accepted in the `Clk` after `RxDone`, which allows back-to-back frames with a single stop bit.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each data, start and stop sample is the majority of `rx_s` at ticks 7, 8 and 9 of its bit window. For the start bit these are counters 6, 7, 8, with the decision taken at counter 8. This rejects a single-tick glitch. The decision point moves by 1 tick, so `RxDone` latency grows by 1 tick.
- **Not defined:** a single sample at the mid-bit tick, as described in Operation.

## Test plan
- **8N1 frame:** after reset, `NBits`=8, drive 0x5A framed start/LSB-first/stop at 16 ticks per bit. Required: one `RxDone` pulse, `RxData`=8'h5A, `FrameErr`=0, `Busy` low afterwards.
- **5-bit frame:** `NBits`=5, send 5'b10110. Required: `RxData`=8'h16. `NBits`=12 with 0xC3: received as 8 bits, `RxData`=8'hC3.
- **False start:** a low pulse of 4 ticks on `Rx` while idle. Required: `Busy` rises then falls at tick 8, no `RxDone`, `RxData` unchanged.
- **Framing error:** 0xFF with the stop bit driven low and `Rx` held low for 40 ticks afterwards. Required: `RxDone`=1 with `FrameErr`=1 and `RxData`=8'hFF. No second frame starts until `Rx` goes high and then low again.
- **Abort and reset:** drop `RxEn` at data bit 3. Required: IDLE next `Clk`, no `RxDone`. Then `Rst` mid-frame: all outputs return to reset values on the next `Clk`.
- **Back-to-back:** send 0x01 then 0x80 with no idle gap. Required: two `RxDone` pulses 160 ticks apart, carrying 8'h01 then 8'h80. With `UART_RX_MAJORITY_EN`, a 1-tick glitch at the mid-point of bit 2 leaves `RxData` correct.
